// File: rtl/ledg_pwm_fader_if.sv
// Signal bundle between the green-LED PIO register and the fader.
// The master side drives the requests; the slave side is the fader.
interface ledg_pwm_fader_if #(
    parameter int NUM_LEDS = 8
);
    logic [NUM_LEDS-1:0] led_req;
    logic                enable;
    logic [NUM_LEDS-1:0] led_out;
    logic                busy;

    modport master (output led_req, enable, input  led_out, busy);
    modport slave  (input  led_req, enable, output led_out, busy);
endinterface

// File: rtl/ledg_pwm_fader.sv
// Per-LED brightness fader: ramps each channel level toward its on/off request
// at a fixed step rate and renders the level as PWM on the LEDG pins.
module ledg_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                enable,
    input  logic                req,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                led_out,
    output logic                busy
);
    localparam logic [PWM_BITS-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            level   <= '0;
            led_out <= 1'b0;
        end else begin
            // MAX is forced on so full brightness has no one-cycle gap per period
            led_out <= enable & ((level == MAX) | (level > pwm_cnt));
            if (tick) begin
                if (req && level != MAX)
                    level <= level + PWM_BITS'(1);
                else if (!req && level != '0)
                    level <= level - PWM_BITS'(1);
            end
        end
    end

    assign busy = req ? (level != MAX) : (level != '0);
endmodule

module ledg_pwm_fader #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 1024
) (
    input  logic            clk,
    input  logic            reset,
    ledg_pwm_fader_if.slave bus
);
    localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [PRE_W-1:0]                   pre_cnt;
    logic [PWM_BITS-1:0]                pwm_cnt;
    logic                               tick;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level;
    logic [NUM_LEDS-1:0]                led_out_w;
    logic [NUM_LEDS-1:0]                busy_w;

    assign tick = bus.enable && (pre_cnt == PRE_LAST);

    // Both counters freeze with enable so a re-enable resumes mid-step
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (bus.enable) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        ledg_pwm_chan #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .enable  (bus.enable),
            .req     (bus.led_req[i]),
            .pwm_cnt (pwm_cnt),
            .level   (level[i]),
            .led_out (led_out_w[i]),
            .busy    (busy_w[i])
        );
    end

    assign bus.led_out = led_out_w;
    assign bus.busy    = |busy_w;
endmodule

// File: tb/tb_ledg_pwm_fader.sv
// Self-checking bench for ledg_pwm_fader: cycle scoreboard plus ramp, duty,
// reversal, enable and reset scenarios.
module tb_ledg_pwm_fader;
    localparam int N  = 8;
    localparam int PB = 4;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_d = 1'b1;
    always #5 clk = ~clk;

    ledg_pwm_fader_if #(.NUM_LEDS(N)) bus ();
    ledg_pwm_fader_if #(.NUM_LEDS(N)) bus_d ();

    ledg_pwm_fader #(.NUM_LEDS(N), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    // slow-step copy so a level can be held long enough to measure duty
    ledg_pwm_fader #(.NUM_LEDS(N), .PWM_BITS(PB), .STEP_DIV(64)) dut_d (
        .clk(clk), .reset(reset_d), .bus(bus_d.slave));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model and scoreboard
    logic [1:0]   m_pre = '0;
    logic [3:0]   m_pwm = '0;
    logic [3:0]   m_lvl [N];
    logic [N-1:0] m_out = '0;
    logic         m_busy, m_tick;
    logic [31:0]  m_lp;
    logic [40:0]  sbq [$];
    logic [40:0]  e;

    initial for (int i = 0; i < N; i++) m_lvl[i] = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_pre = '0;
            m_pwm = '0;
            m_out = '0;
            for (int i = 0; i < N; i++) m_lvl[i] = '0;
        end else begin
            m_tick = bus.enable && (m_pre == 2'd3);
            for (int i = 0; i < N; i++)
                m_out[i] = bus.enable && (m_lvl[i] == 4'd15 || m_lvl[i] > m_pwm);
            if (m_tick)
                for (int i = 0; i < N; i++) begin
                    if (bus.led_req[i] && m_lvl[i] < 4'd15) m_lvl[i] = m_lvl[i] + 4'd1;
                    else if (!bus.led_req[i] && m_lvl[i] > 4'd0) m_lvl[i] = m_lvl[i] - 4'd1;
                end
            if (bus.enable) begin
                m_pre = (m_pre == 2'd3) ? 2'd0 : m_pre + 2'd1;
                m_pwm = (m_pwm == 4'd15) ? 4'd0 : m_pwm + 4'd1;
            end
        end
        m_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_lp[i*4 +: 4] = m_lvl[i];
            if (bus.led_req[i] ? (m_lvl[i] != 4'd15) : (m_lvl[i] != 4'd0)) m_busy = 1'b1;
        end
        sbq.push_back({m_out, m_busy, m_lp});
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("sb_out",  32'(bus.led_out), 32'(e[40:33]));
            chk("sb_busy", 32'(bus.busy),    32'(e[32]));
            chk("sb_lvl",  32'(dut.level),   e[31:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_lvl(input logic [3:0] v, output int n);
        n = 0;
        while (dut.level[0] != v && n < 300) begin
            step();
            n++;
        end
    endtask

    int n, hi0, hi8, hi15, held, first, bigstep;
    logic [3:0] prev;

    initial begin
        bus.enable    = 1'b1;
        bus.led_req   = 8'h00;
        bus_d.enable  = 1'b1;
        bus_d.led_req = 8'h01;

        // duty at levels 0, 8 and 15 on the slow copy
        step(); step();
        reset_d = 1'b0;
        hi0 = 0; hi8 = 0; hi15 = 0;
        for (int k = 1; k <= 985; k++) begin
            step();
            if (k >= 2   && k <= 17)  hi0  += int'(bus_d.led_out[0]);
            if (k >= 514 && k <= 529) hi8  += int'(bus_d.led_out[0]);
            if (k >= 970 && k <= 985) hi15 += int'(bus_d.led_out[0]);
        end
        chk("duty_l0",  32'(hi0),  32'd0);
        chk("duty_l8",  32'(hi8),  32'd8);
        chk("duty_l15", 32'(hi15), 32'd16);

        // reset state
        bus.led_req = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_out", 32'(bus.led_out), 32'h00);
            chk("rst_lvl", 32'(dut.level), 32'h0);
        end
        reset = 1'b0;
        #1 chk("rst_busy", 32'(bus.busy), 32'd1);

        // fade in
        reset = 1'b1; bus.led_req = 8'h01;
        step();
        reset = 1'b0;
        wait_lvl(4'd15, n);
        chk("fade_cycles", 32'(n), 32'd60);
        chk("fade_busy", 32'(bus.busy), 32'd0);
        hi15 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            hi15 += int'(bus.led_out[0]);
            chk("fade_hi_off", 32'(bus.led_out[7:1]), 32'd0);
        end
        chk("fade_const_on", 32'(hi15), 32'd16);

        // reversal at level 10
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_lvl(4'd10, n);
        chk("rev_reach10", 32'(n), 32'd40);
        bus.led_req = 8'h00;
        n = 0; prev = 4'd10; first = -1; bigstep = 0;
        while (dut.level[0] != 4'd0 && n < 300) begin
            step();
            n++;
            if (dut.level[0] != prev && first < 0) first = int'(dut.level[0]);
            if ((dut.level[0] > prev + 4'd1) || (prev > dut.level[0] + 4'd1)) bigstep++;
            prev = dut.level[0];
        end
        chk("rev_first", 32'(first), 32'd9);
        chk("rev_cycles", 32'(n), 32'd40);
        chk("rev_bigstep", 32'(bigstep), 32'd0);

        // enable low at level 6
        reset = 1'b1; bus.led_req = 8'h01;
        step();
        reset = 1'b0;
        wait_lvl(4'd6, n);
        chk("en_reach6", 32'(n), 32'd24);
        bus.enable = 1'b0;
        step();
        chk("en_blank", 32'(bus.led_out), 32'd0);
        held = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (dut.level[0] != 4'd6) held++;
        end
        chk("en_hold", 32'(held), 32'd0);
        bus.enable = 1'b1;
        wait_lvl(4'd7, n);
        chk("en_resume", 32'(n), 32'd4);

        // reset mid-ramp at level 12
        wait_lvl(4'd12, n);
        chk("mid_reach12", 32'(n), 32'd20);
        reset = 1'b1;
        step();
        chk("mid_rst_lvl", 32'(dut.level[0]), 32'd0);
        chk("mid_rst_out", 32'(bus.led_out), 32'd0);
        reset = 1'b0;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
